// File: rtl/sys_pll_reset_sequencer_if.sv
// sys_pll_reset_sequencer_if
// Signal bundle between the PLL reset sequencer and the PLL / system side.
// The sequencer uses the master modport; the PLL/monitor side uses slave.
interface sys_pll_reset_sequencer_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       reset_out;
    logic       fault;
    logic [2:0] state;
    logic [7:0] lock_loss_count;

    modport master (
        input  pll_locked,
        output pll_rst,
        output reset_out,
        output fault,
        output state,
        output lock_loss_count
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  reset_out,
        input  fault,
        input  state,
        input  lock_loss_count
    );
endinterface

// File: rtl/sys_pll_reset_sequencer.sv
// sys_pll_reset_sequencer
// Drives the PLL reset, qualifies the synchronized lock indicator over a
// window before releasing the system reset, re-cycles the PLL on lock loss
// and latches a fault after RETRY_LIMIT consecutive lock timeouts.
// Optional feature macro: PLL_RSTSEQ_STATS_EN (builds the saturating
// lock-loss counter; when undefined lock_loss_count is tied to zero).
module sys_pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT     = 65535,
    parameter int unsigned LOCK_QUAL_CYCLES = 1024,
    parameter int unsigned RETRY_LIMIT      = 4,
    parameter int unsigned CNT_W            = 16
) (
    input  logic                              refclk,
    input  logic                              rst,
    sys_pll_reset_sequencer_if.master         pll
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_QUALIFY   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    typedef struct packed {
        logic pll_rst;
        logic reset_out;
        logic fault;
    } outs_t;

    localparam int unsigned RETRY_W = $clog2(RETRY_LIMIT + 1);

    localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   QUAL_LAST  = CNT_W'(LOCK_QUAL_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_LIMIT - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RETRY_W-1:0] retry_q;
    outs_t              outs_q;
    logic               sync_meta;
    logic               locked_s;

    // Output levels implied by a state; applied to the state being entered
    // so outputs switch on the same edge as the state register.
    function automatic outs_t decode(input state_t s);
        outs_t o;
        o.pll_rst   = (s == S_PLL_RST) || (s == S_FAULT);
        o.reset_out = (s != S_RUN);
        o.fault     = (s == S_FAULT);
        return o;
    endfunction

    // Two-flop synchronizer for the asynchronous PLL lock indicator.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll.pll_locked;
            locked_s  <= sync_meta;
        end
    end

    // Sequencer FSM with shared cycle counter, retry count and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= S_PLL_RST;
            cnt_q   <= '0;
            retry_q <= '0;
            outs_q  <= decode(S_PLL_RST);
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        outs_q  <= decode(S_WAIT_LOCK);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_LOCK: begin
                    // Lock present on the timeout cycle takes priority.
                    if (locked_s) begin
                        state_q <= S_QUALIFY;
                        cnt_q   <= '0;
                        outs_q  <= decode(S_QUALIFY);
                    end else if (cnt_q == TO_LAST) begin
                        retry_q <= retry_q + RETRY_W'(1);
                        cnt_q   <= '0;
                        if (retry_q == RETRY_LAST) begin
                            state_q <= S_FAULT;
                            outs_q  <= decode(S_FAULT);
                        end else begin
                            state_q <= S_PLL_RST;
                            outs_q  <= decode(S_PLL_RST);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_QUALIFY: begin
                    // Lock drop on the final qualification cycle takes priority.
                    if (!locked_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                        outs_q  <= decode(S_WAIT_LOCK);
                    end else if (cnt_q == QUAL_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        retry_q <= '0;
                        outs_q  <= decode(S_RUN);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (!locked_s) begin
                        state_q <= S_PLL_RST;
                        cnt_q   <= '0;
                        outs_q  <= decode(S_PLL_RST);
                    end
                end

                S_FAULT: begin
                    // Sticky until rst.
                end

                default: begin
                    state_q <= S_PLL_RST;
                    cnt_q   <= '0;
                    outs_q  <= decode(S_PLL_RST);
                end
            endcase
        end
    end

    assign pll.pll_rst   = outs_q.pll_rst;
    assign pll.reset_out = outs_q.reset_out;
    assign pll.fault     = outs_q.fault;
    assign pll.state     = state_q;

`ifdef PLL_RSTSEQ_STATS_EN
    logic [7:0] lock_loss_q;

    // Count lock drops seen while running; holds at 255.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_q <= '0;
        end else if ((state_q == S_RUN) && !locked_s && (lock_loss_q != 8'hFF)) begin
            lock_loss_q <= lock_loss_q + 8'd1;
        end
    end

    assign pll.lock_loss_count = lock_loss_q;
`else
    assign pll.lock_loss_count = '0;
`endif

endmodule
